// File: rtl/iic_pkg.sv
// Shared I2C definitions: target FSM states, default device address and R/W bit values.
// Also holds the mapping from each byte-receive state to its ACK state.
package iic_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEV,
        ACK_DEV,
        REG_HI,
        ACK_HI,
        REG_LO,
        ACK_LO,
        WR_BYTE,
        ACK_WR,
        RD_BYTE,
        MACK
    } iic_state_e;

    localparam logic [6:0] IIC_DEV_ADDR = 7'h50;
    localparam logic       IIC_WRITE    = 1'b0;
    localparam logic       IIC_READ     = 1'b1;

    function automatic iic_state_e ack_state(input iic_state_e s);
        case (s)
            DEV:     return ACK_DEV;
            REG_HI:  return ACK_HI;
            REG_LO:  return ACK_LO;
            default: return ACK_WR;
        endcase
    endfunction

endpackage

// File: rtl/iic_line_sync.sv
// Brings scl/sda into the clk_8m domain and derives edge strobes plus START/STOP.
// All strobes are aligned with the synced sda output.
module iic_line_sync (
    input  logic clk_8m,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    // Bit 0 tracks scl, bit 1 tracks sda; idle bus level is high.
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] prev_q;

    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            prev_q  <= 2'b11;
        end else begin
            sync1_q <= {sda, scl};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign scl_rise  = sync2_q[0] & ~prev_q[0];
    assign scl_fall  = ~sync2_q[0] & prev_q[0];
    assign start_det = sync2_q[0] & prev_q[0] & prev_q[1] & ~sync2_q[1];
    assign stop_det  = sync2_q[0] & prev_q[0] & ~prev_q[1] & sync2_q[1];
    assign sda_s     = sync2_q[1];

endmodule

// File: rtl/iic_slave.sv
// I2C target with a 16-bit auto-incrementing register pointer feeding an external register file.
// The bus is oversampled on clk_8m; sda is only ever pulled low or released.
module iic_slave
    import iic_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = IIC_DEV_ADDR
) (
    input  logic        clk_8m,
    input  logic        rst_n,
    input  logic        scl,
    inout  wire         sda,
    output logic [15:0] reg_addr,
    output logic [7:0]  wr_data,
    output logic        wr_en,
    output logic        rd_en,
    input  logic [7:0]  rd_data,
    output logic        busy
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    iic_line_sync u_sync (
        .clk_8m    (clk_8m),
        .rst_n     (rst_n),
        .scl       (scl),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    iic_state_e  state_q;
    logic [3:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic [15:0] reg_addr_q;
    logic [7:0]  wr_data_q;
    logic        wr_en_q, rd_en_q, rd_req_q, busy_q, sda_oe_q, rw_q, mack_q;
    logic [1:0]  rd_pipe_q;
    logic [7:0]  rx_byte;

    assign rx_byte = {shift_q[6:0], sda_s};

    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            reg_addr_q <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_req_q   <= 1'b0;
            rd_pipe_q  <= '0;
            busy_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            rw_q       <= 1'b0;
            mack_q     <= 1'b0;
        end else begin
            wr_en_q   <= 1'b0;
            rd_en_q   <= rd_req_q;
            rd_req_q  <= 1'b0;
            // rd_data is valid two cycles after rd_en; capture it then.
            rd_pipe_q <= {rd_pipe_q[0], rd_en_q};
            if (rd_pipe_q[1]) shift_q <= rd_data;
            if (wr_en_q) reg_addr_q <= reg_addr_q + 16'd1;

            if (stop_det) begin
                state_q   <= IDLE;
                sda_oe_q  <= 1'b0;
                busy_q    <= 1'b0;
                bit_cnt_q <= '0;
            end else if (start_det) begin
                state_q   <= DEV;
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= '0;
            end else begin
                case (state_q)
                    DEV, REG_HI, REG_LO, WR_BYTE: begin
                        if (scl_rise) begin
                            shift_q   <= rx_byte;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                if (state_q == DEV) begin
                                    if (rx_byte[7:1] == DEV_ADDR) begin
                                        busy_q  <= 1'b1;
                                        rw_q    <= rx_byte[0];
                                        rd_en_q <= (rx_byte[0] == IIC_READ);
                                    end else begin
                                        state_q <= IDLE;
                                        busy_q  <= 1'b0;
                                    end
                                end else if (state_q == REG_HI) begin
                                    reg_addr_q[15:8] <= rx_byte;
                                end else if (state_q == REG_LO) begin
                                    reg_addr_q[7:0] <= rx_byte;
                                end else begin
                                    wr_data_q <= rx_byte;
                                    wr_en_q   <= 1'b1;
                                end
                            end
                        end else if (scl_fall && bit_cnt_q == 4'd8) begin
                            state_q  <= ack_state(state_q);
                            sda_oe_q <= 1'b1;
                        end
                    end
                    ACK_DEV: if (scl_fall) begin
                        bit_cnt_q <= '0;
                        if (rw_q == IIC_WRITE) begin
                            state_q  <= REG_HI;
                            sda_oe_q <= 1'b0;
                        end else begin
                            state_q  <= RD_BYTE;
                            sda_oe_q <= ~shift_q[7];
                        end
                    end
                    ACK_HI: if (scl_fall) begin
                        state_q   <= REG_LO;
                        sda_oe_q  <= 1'b0;
                        bit_cnt_q <= '0;
                    end
                    ACK_LO, ACK_WR: if (scl_fall) begin
                        state_q   <= WR_BYTE;
                        sda_oe_q  <= 1'b0;
                        bit_cnt_q <= '0;
                    end
                    RD_BYTE: begin
                        if (scl_rise) bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                state_q  <= MACK;
                                sda_oe_q <= 1'b0;
                                mack_q   <= 1'b0;
                            end else begin
                                shift_q  <= {shift_q[6:0], 1'b0};
                                sda_oe_q <= ~shift_q[6];
                            end
                        end
                    end
                    MACK: begin
                        if (scl_rise) begin
                            if (!sda_s) begin
                                mack_q     <= 1'b1;
                                reg_addr_q <= reg_addr_q + 16'd1;
                                rd_req_q   <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else if (scl_fall && mack_q) begin
                            state_q   <= RD_BYTE;
                            bit_cnt_q <= '0;
                            sda_oe_q  <= ~shift_q[7];
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign reg_addr = reg_addr_q;
    assign wr_data  = wr_data_q;
    assign wr_en    = wr_en_q;
    assign rd_en    = rd_en_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_iic_slave.sv
// Directed bench for iic_slave: a bit-banged master drives the bus and a small
// register-file model answers reads with the low byte of the requested address.
module tb_iic_slave;
    import iic_pkg::*;

    logic        clk_8m    = 1'b0;
    logic        rst_n     = 1'b0;
    logic        scl       = 1'b1;
    logic        sda_m_low = 1'b0;
    logic [7:0]  rd_data   = 8'h00;
    logic [7:0]  rd_stage  = 8'h00;
    logic [15:0] reg_addr;
    logic [7:0]  wr_data;
    logic        wr_en, rd_en, busy;
    wire         sda;

    int tests_run    = 0;
    int tests_failed = 0;
    int rd_en_cnt    = 0;
    int busy_cnt     = 0;
    int slave_low_cnt = 0;
    logic [23:0] wr_log[$];

    pullup (sda);
    assign sda = sda_m_low ? 1'b0 : 1'bz;

    always #5 clk_8m = ~clk_8m;

    iic_slave #(.DEV_ADDR(7'h50)) dut (
        .clk_8m   (clk_8m),
        .rst_n    (rst_n),
        .scl      (scl),
        .sda      (sda),
        .reg_addr (reg_addr),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .busy     (busy)
    );

    // Register file model: data valid two cycles after rd_en.
    always @(posedge clk_8m) begin
        if (rd_en) rd_stage <= reg_addr[7:0];
        rd_data <= rd_stage;
    end

    always @(negedge clk_8m) begin
        if (wr_en) wr_log.push_back({reg_addr, wr_data});
        if (rd_en) rd_en_cnt++;
        if (busy) busy_cnt++;
        if (!sda_m_low && sda == 1'b0) slave_low_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running, required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok %s = 0x%0h", tag, got);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_8m);
        #1;
    endtask

    task automatic i2c_start();
        sda_m_low = 1'b0; cyc(6);
        scl = 1'b1;       cyc(12);
        sda_m_low = 1'b1; cyc(12);
        scl = 1'b0;       cyc(6);
    endtask

    task automatic i2c_stop();
        sda_m_low = 1'b1; cyc(6);
        scl = 1'b1;       cyc(12);
        sda_m_low = 1'b0; cyc(12);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_m_low = ~b[i]; cyc(6);
            scl = 1'b1;        cyc(12);
            scl = 1'b0;        cyc(6);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        sda_m_low = 1'b0; cyc(6);
        scl = 1'b1;       cyc(6);
        ack = (sda == 1'b0);
        cyc(6);
        scl = 1'b0;       cyc(6);
    endtask

    task automatic recv_byte(input logic m_ack, output logic [7:0] d);
        sda_m_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            cyc(6);
            scl = 1'b1; cyc(6);
            d[i] = sda;
            cyc(6);
            scl = 1'b0;
        end
        cyc(6);
        sda_m_low = m_ack; cyc(6);
        scl = 1'b1;        cyc(12);
        scl = 1'b0;        cyc(6);
        sda_m_low = 1'b0;
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         w0, r0, b0, s0;

        cyc(5);
        check("reset_reg_addr", reg_addr, 16'h0000);
        check("reset_wr_data", wr_data, 8'h00);
        check("reset_wr_en", wr_en, 1'b0);
        check("reset_rd_en", rd_en, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_sda_released", sda, 1'b1);
        rst_n = 1'b1;
        cyc(5);

        // Write 0x12 0x34 pointer then two data bytes.
        w0 = wr_log.size();
        i2c_start();
        send_byte(8'hA0, ack); check("t1_ack_dev", ack, 1'b1);
        check("t1_busy", busy, 1'b1);
        send_byte(8'h12, ack); check("t1_ack_hi", ack, 1'b1);
        send_byte(8'h34, ack); check("t1_ack_lo", ack, 1'b1);
        send_byte(8'hAB, ack); check("t1_ack_d0", ack, 1'b1);
        send_byte(8'hCD, ack); check("t1_ack_d1", ack, 1'b1);
        i2c_stop();
        check("t1_wr_count", wr_log.size() - w0, 2);
        check("t1_wr0", wr_log[w0], 24'h1234AB);
        check("t1_wr1", wr_log[w0 + 1], 24'h1235CD);
        check("t1_busy_after_stop", busy, 1'b0);
        check("t1_reg_addr", reg_addr, 16'h1236);

        // Set pointer 0x0010, repeated START, read two bytes.
        r0 = rd_en_cnt;
        i2c_start();
        send_byte(8'hA0, ack); check("t2_ack_dev_w", ack, 1'b1);
        send_byte(8'h00, ack);
        send_byte(8'h10, ack); check("t2_ack_lo", ack, 1'b1);
        i2c_start();
        send_byte(8'hA1, ack); check("t2_ack_dev_r", ack, 1'b1);
        recv_byte(1'b1, d);    check("t2_rd0", d, 8'h10);
        recv_byte(1'b0, d);    check("t2_rd1", d, 8'h11);
        i2c_stop();
        check("t2_reg_addr", reg_addr, 16'h0011);
        check("t2_rd_en_count", rd_en_cnt - r0, 2);

        // Wrong device address.
        w0 = wr_log.size(); r0 = rd_en_cnt; b0 = busy_cnt; s0 = slave_low_cnt;
        i2c_start();
        send_byte(8'hA2, ack); check("t3_nack_dev", ack, 1'b0);
        send_byte(8'h00, ack); check("t3_nack_data", ack, 1'b0);
        i2c_stop();
        check("t3_sda_never_low", slave_low_cnt - s0, 0);
        check("t3_no_wr", wr_log.size() - w0, 0);
        check("t3_no_rd", rd_en_cnt - r0, 0);
        check("t3_busy_never", busy_cnt - b0, 0);

        // Pointer wrap.
        w0 = wr_log.size();
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'hFF, ack);
        send_byte(8'hFF, ack);
        send_byte(8'h11, ack);
        send_byte(8'h22, ack);
        i2c_stop();
        check("t4_wr_count", wr_log.size() - w0, 2);
        check("t4_wr0", wr_log[w0], 24'hFFFF11);
        check("t4_wr1", wr_log[w0 + 1], 24'h000022);
        check("t4_reg_addr", reg_addr, 16'h0001);

        // STOP after 5 bits of a data byte.
        w0 = wr_log.size();
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h20, ack);
        send_byte(8'h00, ack);
        send_bits(8'h5A, 5);
        i2c_stop();
        check("t5_no_wr", wr_log.size() - w0, 0);
        check("t5_reg_addr", reg_addr, 16'h2000);
        check("t5_state", dut.state_q, IDLE);
        check("t5_busy", busy, 1'b0);

        // Reset while the target holds the ACK low.
        i2c_start();
        send_bits(8'hA0, 8);
        sda_m_low = 1'b0;
        cyc(8);
        check("t6_ack_driven", sda, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("t6_sda_released", sda, 1'b1);
        @(negedge clk_8m);
        check("t6_reg_addr", reg_addr, 16'h0000);
        check("t6_wr_data", wr_data, 8'h00);
        check("t6_busy", busy, 1'b0);
        check("t6_rd_en", rd_en, 1'b0);
        cyc(4);
        rst_n = 1'b1;
        cyc(4);
        scl = 1'b1; cyc(12);
        scl = 1'b0; cyc(6);
        i2c_stop();
        w0 = wr_log.size();
        i2c_start();
        send_byte(8'hA0, ack); check("t6_ack_after_reset", ack, 1'b1);
        send_byte(8'h00, ack);
        send_byte(8'h05, ack);
        send_byte(8'h77, ack);
        i2c_stop();
        check("t6_wr_count", wr_log.size() - w0, 1);
        check("t6_wr0", wr_log[w0], 24'h000577);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
